// File: rtl/dispatch_stage_if.sv
// Decode-to-reservation-station bus of the two-wide dispatch stage.
// The slave modport is the dispatch stage; the master side feeds pairs and observes the strobes.
interface dispatch_stage_if #(
    parameter int unsigned DATA_W = 76,
    parameter int unsigned N_CPX  = 2,
    parameter int unsigned N_SMP  = 2,
    parameter int unsigned N_FP   = 2,
    parameter int unsigned CNT_W  = 16
);
    logic [DATA_W+1:0]       inst_a;
    logic [DATA_W+1:0]       inst_b;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [N_CPX-1:0]        cpx_empty;
    logic [N_SMP-1:0]        smp_empty;
    logic [N_FP-1:0]         fp_empty;
    logic [N_CPX*DATA_W-1:0] cpx_data;
    logic [N_CPX-1:0]        cpx_valid;
    logic [N_SMP*DATA_W-1:0] smp_data;
    logic [N_SMP-1:0]        smp_valid;
    logic [N_FP*DATA_W-1:0]  fp_data;
    logic [N_FP-1:0]         fp_valid;
    logic [CNT_W-1:0]        stall_cnt;

    modport master (
        output inst_a, inst_b, in_valid, flush, cpx_empty, smp_empty, fp_empty,
        input  in_ready, cpx_data, cpx_valid, smp_data, smp_valid, fp_data, fp_valid, stall_cnt
    );

    modport slave (
        input  inst_a, inst_b, in_valid, flush, cpx_empty, smp_empty, fp_empty,
        output in_ready, cpx_data, cpx_valid, smp_data, smp_valid, fp_data, fp_valid, stall_cnt
    );
endinterface

// File: rtl/dispatch_stage.sv
// Two-wide in-order dispatch from a 2-slot hold buffer into complex/simple/FP reservation stations,
// with registered per-entry write strobes, partial dispatch, flush and a saturating stall counter.
module dispatch_stage #(
    parameter int unsigned DATA_W = 76,
    parameter int unsigned N_CPX  = 2,
    parameter int unsigned N_SMP  = 2,
    parameter int unsigned N_FP   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input logic             clk,
    input logic             rst_n,
    dispatch_stage_if.slave io
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PAIR  = 2'd1,
        S_TAIL  = 2'd2
    } state_e;

    typedef struct packed {
        logic             ok;
        logic [N_CPX-1:0] cpx;
        logic [N_SMP-1:0] smp;
        logic [N_FP-1:0]  fp;
    } alloc_t;

    // One-hot pick of the highest-index available entry for the instruction's class.
    function automatic alloc_t alloc(
        input logic [1:0]       ctrl,
        input logic [N_CPX-1:0] ac,
        input logic [N_SMP-1:0] as,
        input logic [N_FP-1:0]  af
    );
        alloc_t r;
        r = '0;
        case (ctrl)
            2'b11: begin
                for (int unsigned i = 0; i < N_SMP; i++)
                    if (as[i]) begin r.smp = '0; r.smp[i] = 1'b1; end
                if (as == '0)
                    for (int unsigned i = 0; i < N_CPX; i++)
                        if (ac[i]) begin r.cpx = '0; r.cpx[i] = 1'b1; end
            end
            2'b01: begin
                for (int unsigned i = 0; i < N_CPX; i++)
                    if (ac[i]) begin r.cpx = '0; r.cpx[i] = 1'b1; end
            end
            2'b10: begin
                for (int unsigned i = 0; i < N_FP; i++)
                    if (af[i]) begin r.fp = '0; r.fp[i] = 1'b1; end
            end
            default: ;
        endcase
        r.ok = (ctrl == 2'b00) || (|r.cpx) || (|r.smp) || (|r.fp);
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic [DATA_W+1:0]       slot_a_q, slot_a_d;
    logic [DATA_W+1:0]       slot_b_q, slot_b_d;
    logic [N_CPX-1:0]        cpx_valid_q, cpx_valid_d;
    logic [N_SMP-1:0]        smp_valid_q, smp_valid_d;
    logic [N_FP-1:0]         fp_valid_q, fp_valid_d;
    logic [N_CPX*DATA_W-1:0] cpx_data_q, cpx_data_d;
    logic [N_SMP*DATA_W-1:0] smp_data_q, smp_data_d;
    logic [N_FP*DATA_W-1:0]  fp_data_q, fp_data_d;
    logic [CNT_W-1:0]        stall_q, stall_d;

    alloc_t                  al_a, al_b;
    logic [N_CPX-1:0]        avail_cpx, wa_cpx, wb_cpx;
    logic [N_SMP-1:0]        avail_smp, wa_smp, wb_smp;
    logic [N_FP-1:0]         avail_fp, wa_fp, wb_fp;
    logic [DATA_W-1:0]       pay_a, pay_b;
    logic                    held_a, held_b, disp_a, disp_b, drained, ready, accept;

    // The previous edge's write strobes double as the reserve mask: both hold exactly
    // the entries written last cycle and both clear on flush/reset.
    always_comb begin
        avail_cpx = io.cpx_empty & ~cpx_valid_q;
        avail_smp = io.smp_empty & ~smp_valid_q;
        avail_fp  = io.fp_empty  & ~fp_valid_q;

        al_a = alloc(slot_a_q[1:0], avail_cpx, avail_smp, avail_fp);
        al_b = alloc(slot_b_q[1:0], avail_cpx & ~al_a.cpx, avail_smp & ~al_a.smp,
                     avail_fp & ~al_a.fp);

        held_a  = (state_q != S_EMPTY);
        held_b  = (state_q == S_PAIR);
        disp_a  = held_a && al_a.ok;
        disp_b  = held_b && disp_a && al_b.ok;
        drained = (!held_a || disp_a) && (!held_b || disp_b);
        ready   = rst_n && !io.flush && drained;
        accept  = io.in_valid && ready;

        pay_a  = slot_a_q[DATA_W+1:2];
        pay_b  = slot_b_q[DATA_W+1:2];
        wa_cpx = (!io.flush && disp_a) ? al_a.cpx : '0;
        wa_smp = (!io.flush && disp_a) ? al_a.smp : '0;
        wa_fp  = (!io.flush && disp_a) ? al_a.fp  : '0;
        wb_cpx = (!io.flush && disp_b) ? al_b.cpx : '0;
        wb_smp = (!io.flush && disp_b) ? al_b.smp : '0;
        wb_fp  = (!io.flush && disp_b) ? al_b.fp  : '0;
    end

    always_comb begin
        cpx_valid_d = wa_cpx | wb_cpx;
        smp_valid_d = wa_smp | wb_smp;
        fp_valid_d  = wa_fp  | wb_fp;
        cpx_data_d  = '0;
        smp_data_d  = '0;
        fp_data_d   = '0;
        for (int unsigned i = 0; i < N_CPX; i++)
            cpx_data_d[i*DATA_W +: DATA_W] = wa_cpx[i] ? pay_a : (wb_cpx[i] ? pay_b : '0);
        for (int unsigned i = 0; i < N_SMP; i++)
            smp_data_d[i*DATA_W +: DATA_W] = wa_smp[i] ? pay_a : (wb_smp[i] ? pay_b : '0);
        for (int unsigned i = 0; i < N_FP; i++)
            fp_data_d[i*DATA_W +: DATA_W] = wa_fp[i] ? pay_a : (wb_fp[i] ? pay_b : '0);
    end

    always_comb begin
        state_d  = state_q;
        slot_a_d = slot_a_q;
        slot_b_d = slot_b_q;
        stall_d  = stall_q;
        if (io.flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: ;
                S_PAIR: begin
                    if (disp_a && !disp_b) begin
                        state_d  = S_TAIL;
                        slot_a_d = slot_b_q;
                    end else if (disp_b) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TAIL: if (disp_a) state_d = S_EMPTY;
                default: state_d = S_EMPTY;
            endcase
            if (accept) begin
                state_d  = S_PAIR;
                slot_a_d = io.inst_a;
                slot_b_d = io.inst_b;
            end
            if (held_a && !disp_a && !(&stall_q))
                stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            slot_a_q    <= '0;
            slot_b_q    <= '0;
            cpx_valid_q <= '0;
            smp_valid_q <= '0;
            fp_valid_q  <= '0;
            cpx_data_q  <= '0;
            smp_data_q  <= '0;
            fp_data_q   <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            slot_a_q    <= slot_a_d;
            slot_b_q    <= slot_b_d;
            cpx_valid_q <= cpx_valid_d;
            smp_valid_q <= smp_valid_d;
            fp_valid_q  <= fp_valid_d;
            cpx_data_q  <= cpx_data_d;
            smp_data_q  <= smp_data_d;
            fp_data_q   <= fp_data_d;
            stall_q     <= stall_d;
        end
    end

    assign io.in_ready  = ready;
    assign io.cpx_valid = cpx_valid_q;
    assign io.smp_valid = smp_valid_q;
    assign io.fp_valid  = fp_valid_q;
    assign io.cpx_data  = cpx_data_q;
    assign io.smp_data  = smp_data_q;
    assign io.fp_data   = fp_data_q;
    assign io.stall_cnt = stall_q;
endmodule

// File: tb/tb_dispatch_stage.sv
// Bench for dispatch_stage: a queue-based reference model checked every cycle on a 16-bit and a
// 4-bit stall-counter instance sharing one stimulus stream, plus hand-computed directed checks.
module tb_dispatch_stage;
    localparam int unsigned DW = 76;
    localparam int unsigned NC = 2;
    localparam int unsigned NS = 2;
    localparam int unsigned NF = 2;
    localparam int unsigned IW = DW + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dispatch_stage_if #(.DATA_W(DW), .N_CPX(NC), .N_SMP(NS), .N_FP(NF), .CNT_W(16)) b16 ();
    dispatch_stage_if #(.DATA_W(DW), .N_CPX(NC), .N_SMP(NS), .N_FP(NF), .CNT_W(4))  b4 ();

    dispatch_stage #(.DATA_W(DW), .N_CPX(NC), .N_SMP(NS), .N_FP(NF), .CNT_W(16))
        u16 (.clk(clk), .rst_n(rst_n), .io(b16));
    dispatch_stage #(.DATA_W(DW), .N_CPX(NC), .N_SMP(NS), .N_FP(NF), .CNT_W(4))
        u4 (.clk(clk), .rst_n(rst_n), .io(b4));

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          chk_en = 1'b0;

    // Stimulus mirror used by the model
    logic          m_flush, m_valid;
    logic [IW-1:0] m_a, m_b;
    logic [1:0]    m_ce, m_se, m_fe;

    // Reference model state and expectations
    logic [IW-1:0]    mq[$];
    logic [NC-1:0]    exp_cv;
    logic [NS-1:0]    exp_sv;
    logic [NF-1:0]    exp_fv;
    logic [NC*DW-1:0] exp_cd;
    logic [NS*DW-1:0] exp_sd;
    logic [NF*DW-1:0] exp_fd;
    int unsigned      exp_st16, exp_st4;
    bit               exp_ready;
    logic             got_ready;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [1:0] c);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return {r[DW-1:0], c};
    endfunction

    function automatic int top(input bit [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            if (v[i]) return i;
        return -1;
    endfunction

    // cls: -1 blocked, 0 bubble, 1 complex, 2 simple, 3 FP
    function automatic int pick(input logic [1:0] ctrl, input bit [7:0] ac, input bit [7:0] as,
                                input bit [7:0] af, output int cls);
        int idx;
        idx = -1;
        cls = -1;
        case (ctrl)
            2'b00: cls = 0;
            2'b11: begin
                idx = top(as, NS);
                if (idx >= 0) cls = 2;
                else begin idx = top(ac, NC); if (idx >= 0) cls = 1; end
            end
            2'b01: begin idx = top(ac, NC); if (idx >= 0) cls = 1; end
            default: begin idx = top(af, NF); if (idx >= 0) cls = 3; end
        endcase
        return idx;
    endfunction

    task automatic model_step();
        bit [7:0] ac, as, af;
        int cls, idx, nd;
        logic [DW-1:0] pl;
        logic [NC-1:0] ncv; logic [NS-1:0] nsv; logic [NF-1:0] nfv;
        logic [NC*DW-1:0] ncd; logic [NS*DW-1:0] nsd; logic [NF*DW-1:0] nfd;
        exp_ready = 1'b0;
        ncv = '0; nsv = '0; nfv = '0; ncd = '0; nsd = '0; nfd = '0;
        if (!rst_n) begin
            mq.delete();
            exp_st16 = 0;
            exp_st4  = 0;
        end else if (m_flush) begin
            mq.delete();
        end else begin
            ac = 8'(m_ce & ~exp_cv);
            as = 8'(m_se & ~exp_sv);
            af = 8'(m_fe & ~exp_fv);
            nd = 0;
            for (int k = 0; k < mq.size(); k++) begin
                idx = pick(mq[k][1:0], ac, as, af, cls);
                if (cls < 0) break;
                pl = mq[k][IW-1:2];
                case (cls)
                    1: begin ncv[idx] = 1'b1; ncd[idx*DW +: DW] = pl; ac[idx] = 1'b0; end
                    2: begin nsv[idx] = 1'b1; nsd[idx*DW +: DW] = pl; as[idx] = 1'b0; end
                    3: begin nfv[idx] = 1'b1; nfd[idx*DW +: DW] = pl; af[idx] = 1'b0; end
                    default: ;
                endcase
                nd++;
            end
            if (mq.size() > 0 && nd == 0) begin
                if (exp_st16 < 65535) exp_st16++;
                if (exp_st4 < 15) exp_st4++;
            end
            exp_ready = (nd == mq.size());
            repeat (nd) void'(mq.pop_front());
            if (exp_ready && m_valid) begin
                mq.push_back(m_a);
                mq.push_back(m_b);
            end
        end
        exp_cv = ncv; exp_sv = nsv; exp_fv = nfv;
        exp_cd = ncd; exp_sd = nsd; exp_fd = nfd;
    endtask

    task automatic cyc(input bit r, input bit f, input bit v, input logic [IW-1:0] a,
                       input logic [IW-1:0] b, input logic [1:0] ce, input logic [1:0] se,
                       input logic [1:0] fe);
        @(negedge clk);
        rst_n = r; m_flush = f; m_valid = v; m_a = a; m_b = b; m_ce = ce; m_se = se; m_fe = fe;
        b16.flush = f; b16.in_valid = v; b16.inst_a = a; b16.inst_b = b;
        b16.cpx_empty = ce; b16.smp_empty = se; b16.fp_empty = fe;
        b4.flush = f; b4.in_valid = v; b4.inst_a = a; b4.inst_b = b;
        b4.cpx_empty = ce; b4.smp_empty = se; b4.fp_empty = fe;
        #1;
        model_step();
        got_ready = b16.in_ready;
        chk("in_ready", b16.in_ready, exp_ready);
        chk("in_ready_c4", b4.in_ready, exp_ready);
        chk_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("cpx_valid", b16.cpx_valid, exp_cv);
            chk("smp_valid", b16.smp_valid, exp_sv);
            chk("fp_valid",  b16.fp_valid,  exp_fv);
            chk("cpx_data",  b16.cpx_data,  exp_cd);
            chk("smp_data",  b16.smp_data,  exp_sd);
            chk("fp_data",   b16.fp_data,   exp_fd);
            chk("stall16",   b16.stall_cnt, exp_st16);
            chk("cpx_valid_c4", b4.cpx_valid, exp_cv);
            chk("smp_valid_c4", b4.smp_valid, exp_sv);
            chk("fp_valid_c4",  b4.fp_valid,  exp_fv);
            chk("data_c4", {b4.cpx_data, b4.smp_data, b4.fp_data}, {exp_cd, exp_sd, exp_fd});
            chk("stall4",  b4.stall_cnt, exp_st4);
        end
    end

    initial begin
        logic [IW-1:0] a, b;
        int unsigned s0;
        exp_cv = '0; exp_sv = '0; exp_fv = '0; exp_cd = '0; exp_sd = '0; exp_fd = '0;
        exp_st16 = 0; exp_st4 = 0;

        cyc(0, 0, 0, mk(0), mk(0), 3, 3, 3);
        cyc(0, 0, 0, mk(0), mk(0), 3, 3, 3);
        chk("rst_ready", got_ready, 1'b0);
        chk("rst_stall", b16.stall_cnt, 16'd0);
        chk("rst_valids", {b16.cpx_valid, b16.smp_valid, b16.fp_valid}, 6'd0);

        // Two simple ops into simple entries 1 (A) and 0 (B)
        a = mk(2'b11); b = mk(2'b11);
        cyc(1, 0, 1, a, b, 3, 3, 3);
        cyc(1, 0, 0, mk(0), mk(0), 3, 3, 3);
        chk("t1_ready", got_ready, 1'b1);
        chk("t1_smp_valid", b16.smp_valid, 2'b11);
        chk("t1_smp_data", b16.smp_data, {a[IW-1:2], b[IW-1:2]});

        // Simple RS full: simple op overflows to complex
        a = mk(2'b11); b = mk(2'b01);
        cyc(1, 0, 1, a, b, 3, 0, 3);
        cyc(1, 0, 0, mk(0), mk(0), 3, 0, 3);
        chk("t2_cpx_valid", b16.cpx_valid, 2'b11);
        chk("t2_smp_valid", b16.smp_valid, 2'b00);
        chk("t2_cpx_data", b16.cpx_data, {a[IW-1:2], b[IW-1:2]});

        // Partial dispatch, then reserve mask blocks the tail for one cycle
        a = mk(2'b10); b = mk(2'b10);
        cyc(1, 0, 1, a, b, 3, 3, 2'b01);
        cyc(1, 0, 0, mk(0), mk(0), 3, 3, 2'b01);
        chk("t3_ready_tail", got_ready, 1'b0);
        chk("t3_fp_a", b16.fp_valid, 2'b01);
        s0 = b16.stall_cnt;
        cyc(1, 0, 0, mk(0), mk(0), 3, 3, 2'b01);
        chk("t3_fp_block", b16.fp_valid, 2'b00);
        chk("t3_stall", b16.stall_cnt, 16'(s0 + 1));
        cyc(1, 0, 0, mk(0), mk(0), 3, 3, 2'b10);
        chk("t3_fp_b", b16.fp_valid, 2'b10);
        chk("t3_fp_data", b16.fp_data[2*DW-1:DW], b[IW-1:2]);

        // Blocked head holds back a dispatchable tail
        a = mk(2'b01); b = mk(2'b10);
        cyc(1, 0, 1, a, b, 0, 3, 3);
        s0 = b16.stall_cnt;
        repeat (5) cyc(1, 0, 1, mk(3), mk(3), 0, 3, 3);
        chk("t4_ready", got_ready, 1'b0);
        chk("t4_stall", b16.stall_cnt, 16'(s0 + 5));
        cyc(1, 0, 0, mk(0), mk(0), 2'b01, 3, 3);
        chk("t4_cpx", b16.cpx_valid, 2'b01);
        chk("t4_fp", b16.fp_valid, 2'b10);

        // Flush in TAIL beats a pending accept
        cyc(1, 0, 1, mk(2'b10), mk(2'b10), 3, 3, 2'b01);
        cyc(1, 0, 0, mk(0), mk(0), 3, 3, 2'b01);
        cyc(1, 1, 1, mk(2'b11), mk(2'b11), 3, 3, 3);
        chk("t5_flush_ready", got_ready, 1'b0);
        chk("t5_flush_valids", {b16.cpx_valid, b16.smp_valid, b16.fp_valid}, 6'd0);
        cyc(1, 0, 0, mk(0), mk(0), 3, 3, 3);
        chk("t5_after_ready", got_ready, 1'b1);
        chk("t5_no_accept", {b16.cpx_valid, b16.smp_valid, b16.fp_valid}, 6'd0);

        // 4-bit counter saturates; reset mid-PAIR clears everything
        cyc(1, 0, 1, mk(2'b01), mk(2'b00), 0, 3, 3);
        repeat (20) cyc(1, 0, 0, mk(0), mk(0), 0, 3, 3);
        chk("t6_sat4", b4.stall_cnt, 4'hF);
        cyc(0, 0, 1, mk(3), mk(3), 3, 3, 3);
        chk("t6_rst_stall", b4.stall_cnt, 4'h0);
        chk("t6_rst_valids", {b16.cpx_valid, b16.smp_valid, b16.fp_valid}, 6'd0);

        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom % 100) != 0, ($urandom % 16) == 0, $urandom % 2,
                mk(2'($urandom)), mk(2'($urandom)),
                2'($urandom), 2'($urandom), 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
